// File: rtl/alu_result_register.sv
// alu_result_register
//   Output stage behind the lab ALU. A debounced-by-synchronizer pushbutton
//   press captures the live ALU result into q. q is also fed back to the ALU
//   as its B operand.
//   Six active-low 7-segment drives (bit0=a .. bit6=g):
//     hex0/hex1 : registered value q (blank until the first load)
//     hex2      : load counter when LOAD_COUNT_EN is defined, else blank
//     hex3      : always blank
//     hex4/hex5 : live alu_result
//   Optional feature macro: LOAD_COUNT_EN (4-bit wrapping load counter on hex2).
module alu_result_register #(
    parameter int WIDTH       = 8,  // 1..8; displays show the value zero-extended to 8 bits
    parameter int SYNC_STAGES = 2   // >= 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             load_n,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             load_pulse,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low hex glyphs, bit0 = segment a.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // The synchronizer and history flop reset to 0 ("pressed") so that a
    // button held through reset release cannot look like a fresh press.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WIDTH-1:0]       value_q, value_d;
    logic                   valid_q, valid_d;
    logic                   pulse_q, pulse_d;
    logic                   press;

    // Press detection and load next-state: a 1->0 transition on the
    // synchronized button loads the current (old-q based) ALU result.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], load_n};
        hist_d  = sync_q[SYNC_STAGES-1];
        press   = hist_q & ~sync_q[SYNC_STAGES-1];
        pulse_d = press;
        value_d = value_q;
        valid_d = valid_q;
        if (press) begin
            value_d = alu_result;
            valid_d = 1'b1;
        end
    end

    // Register update; q and load_pulse change on the same edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            value_q <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            value_q <= value_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
        end
    end

    assign q          = value_q;
    assign q_valid    = valid_q;
    assign load_pulse = pulse_q;

    // ------------------------------------------------------------------
    // Optional load counter
    // ------------------------------------------------------------------
`ifdef LOAD_COUNT_EN
    logic [3:0] cnt_q, cnt_d;

    // Count loads, wrapping 15 -> 0 naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (pulse_q) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hex2 = hex_glyph(cnt_q);
`else
    assign hex2 = SEG_BLANK;
`endif

    // ------------------------------------------------------------------
    // Displays
    // ------------------------------------------------------------------
    logic [7:0] q_ext;
    logic [7:0] alu_ext;

    // Zero-extend both values to a full byte so narrow builds still
    // drive two digits each.
    always_comb begin
        q_ext                 = '0;
        q_ext[WIDTH-1:0]      = value_q;
        alu_ext               = '0;
        alu_ext[WIDTH-1:0]    = alu_result;
    end

    // Registered value is blank until something has been loaded.
    always_comb begin
        hex0 = SEG_BLANK;
        hex1 = SEG_BLANK;
        if (valid_q) begin
            hex0 = hex_glyph(q_ext[3:0]);
            hex1 = hex_glyph(q_ext[7:4]);
        end
    end

    assign hex3 = SEG_BLANK;
    assign hex4 = hex_glyph(alu_ext[3:0]);
    assign hex5 = hex_glyph(alu_ext[7:4]);

endmodule
